// File: rtl/ps2_host_port_pkg.sv
// Shared definitions for the PS/2 host port: frame geometry, transmit FSM
// state encoding and the odd-parity helper used by both directions.
package ps2_host_port_pkg;

  // Start + 8 data + parity + stop.
  localparam int FRAME_BITS = 11;
  localparam logic [3:0] RX_LAST_BIT = 4'(FRAME_BITS - 1);

  // Transmit bit counter values: 0..7 data, then parity, then stop.
  localparam logic [3:0] TX_PAR_IDX  = 4'd8;
  localparam logic [3:0] TX_STOP_IDX = 4'd9;

  localparam int TIMER_W = 17;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INHIBIT = 3'd1,
    ST_START   = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_ACK     = 3'd4,
    ST_WAITUP  = 3'd5
  } tx_state_e;

  // Parity bit that makes the 9-bit group (data + parity) contain an odd
  // number of ones.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_port_fifo.sv
// Synchronous show-ahead FIFO with count-based full/empty.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   en                  tick enable; push/pop only take effect when high
//   push, push_data     write request and data (ignored when full unless popping)
//   pop                 read request (ignored when empty)
//   head_data           entry at the read pointer
//   full, empty         occupancy flags
module ps2_host_port_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign head_data = mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted when the same tick frees a slot.
  assign do_pop  = en & pop & ~empty;
  assign do_push = en & push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/ps2_host_port.sv
// PS/2 host transceiver: receives device frames into an RX FIFO and sends
// queued host commands from a TX FIFO with request-to-send and ACK handling.
// Ports:
//   clk, reset, clk7_en       clock, sync active-high reset, tick enable
//   ps2_clk_i/ps2_dat_i       pad inputs; ps2_clk_o/ps2_dat_o open-collector drives (0 = pull low)
//   tx_data/tx_valid/tx_ready command byte push interface
//   rx_data/rx_valid/rx_ready received byte pop interface
//   hold                      inhibit the device while idle
//   rx_err/rx_ovf/tx_err      one-tick error pulses
//   busy                      transmit FSM not idle
module ps2_host_port
  import ps2_host_port_pkg::*;
#(
  parameter int INHIBIT_TICKS = 710,
  parameter int FRAME_TIMEOUT = 14200,
  parameter int TX_TIMEOUT    = 105000,
  parameter int RX_DEPTH      = 8,
  parameter int TX_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk7_en,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_o,
  output logic       ps2_dat_o,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic       hold,
  output logic       rx_err,
  output logic       rx_ovf,
  output logic       tx_err,
  output logic       busy
);

  localparam logic [TIMER_W-1:0] INH_LAST = TIMER_W'(INHIBIT_TICKS - 1);
  localparam logic [TIMER_W-1:0] FRAME_TO = TIMER_W'(FRAME_TIMEOUT);
  localparam logic [TIMER_W-1:0] TX_TO    = TIMER_W'(TX_TIMEOUT);

  logic [1:0] clk_sync_q, dat_sync_q;
  logic       clk_prev_q;
  logic       clk_s, dat_s, fall;

  tx_state_e        state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [3:0]       rx_cnt_q, rx_cnt_d;
  logic [9:0]       rx_sr_q, rx_sr_d;
  logic [3:0]       tx_cnt_q, tx_cnt_d;
  logic             clk_o_q, clk_o_d, dat_o_q, dat_o_d;
  logic             rx_err_q, rx_err_d, rx_ovf_q, rx_ovf_d;
  logic             tx_err_q, tx_err_d, busy_q, busy_d;

  logic       rx_push, rx_pop, rx_full, rx_empty, rx_en, rx_active;
  logic       tx_pop, tx_full, tx_empty;
  logic [7:0] tx_head;

  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];
  assign fall  = clk_prev_q & ~clk_s;

  assign ps2_clk_o = clk_o_q;
  assign ps2_dat_o = dat_o_q;
  assign rx_err    = rx_err_q;
  assign rx_ovf    = rx_ovf_q;
  assign tx_err    = tx_err_q;
  assign busy      = busy_q;
  assign rx_valid  = ~rx_empty;
  assign tx_ready  = ~tx_full;
  assign rx_pop    = rx_valid & rx_ready;
  assign rx_active = (rx_cnt_q != '0);

  // Framing only runs while the device owns the clock; this keeps our own
  // inhibit edges and the device ACK bit out of the RX path.
  assign rx_en = ((state_q == ST_IDLE) || (state_q == ST_WAITUP)) && clk_o_q;

  ps2_host_port_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .en(clk7_en),
    .push(rx_push), .push_data(rx_sr_q[8:1]), .pop(rx_pop),
    .head_data(rx_data), .full(rx_full), .empty(rx_empty)
  );

  ps2_host_port_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .en(clk7_en),
    .push(tx_valid), .push_data(tx_data), .pop(tx_pop),
    .head_data(tx_head), .full(tx_full), .empty(tx_empty)
  );

  // RX shifter: bits enter at the top, so after ten falls sr[0] is the start
  // bit, sr[8:1] the data and sr[9] the parity; the stop bit is read live.
  always_comb begin
    rx_cnt_d = rx_cnt_q;
    rx_sr_d  = rx_sr_q;
    rx_push  = 1'b0;
    rx_err_d = 1'b0;
    rx_ovf_d = 1'b0;
    if (!rx_en) begin
      rx_cnt_d = '0;
    end else if (fall) begin
      if (rx_cnt_q == RX_LAST_BIT) begin
        rx_cnt_d = '0;
        if (!rx_sr_q[0] && (rx_sr_q[9] == odd_parity(rx_sr_q[8:1])) && dat_s) begin
          if (rx_full && !rx_pop) rx_ovf_d = 1'b1;
          else                    rx_push  = 1'b1;
        end else begin
          rx_err_d = 1'b1;
        end
      end else begin
        rx_sr_d  = {dat_s, rx_sr_q[9:1]};
        rx_cnt_d = rx_cnt_q + 4'd1;
      end
    end else if (rx_active && (timer_q > FRAME_TO)) begin
      rx_cnt_d = '0;
      rx_err_d = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    tx_cnt_d = tx_cnt_q;
    clk_o_d  = clk_o_q;
    dat_o_d  = dat_o_q;
    tx_err_d = 1'b0;
    tx_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        clk_o_d = 1'b1;
        dat_o_d = 1'b1;
        if (hold && !rx_active) begin
          clk_o_d = 1'b0;
        end else if (!tx_empty && !rx_active && !rx_full) begin
          state_d = ST_INHIBIT;
          clk_o_d = 1'b0;
        end
      end
      ST_INHIBIT: begin
        if (timer_q >= INH_LAST) begin
          state_d = ST_START;
          dat_o_d = 1'b0;
        end
      end
      ST_START: begin
        // Start bit stays on data while the clock is handed to the device.
        state_d  = ST_SHIFT;
        clk_o_d  = 1'b1;
        tx_cnt_d = '0;
      end
      ST_SHIFT: begin
        if (fall) begin
          tx_cnt_d = tx_cnt_q + 4'd1;
          if (tx_cnt_q == TX_STOP_IDX) begin
            dat_o_d = 1'b1;
            state_d = ST_ACK;
          end else if (tx_cnt_q == TX_PAR_IDX) begin
            dat_o_d = odd_parity(tx_head);
          end else begin
            dat_o_d = tx_head[tx_cnt_q[2:0]];
          end
        end
      end
      ST_ACK: begin
        if (fall) begin
          if (!dat_s) begin
            tx_pop  = 1'b1;
            state_d = ST_WAITUP;
          end else begin
            tx_err_d = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      ST_WAITUP: begin
        if (clk_s && dat_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Watchdog once the device owns the clock; the entry stays queued.
    if ((state_q == ST_SHIFT || state_q == ST_ACK || state_q == ST_WAITUP)
        && (timer_q >= TX_TO)) begin
      tx_err_d = 1'b1;
      tx_pop   = 1'b0;
      state_d  = ST_IDLE;
      clk_o_d  = 1'b1;
      dat_o_d  = 1'b1;
    end
  end

  always_comb begin
    busy_d = (state_d != ST_IDLE);
    if ((state_d != state_q) || fall) timer_d = '0;
    else if (timer_q != '1)           timer_d = timer_q + TIMER_W'(1);
    else                              timer_d = timer_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      rx_cnt_q   <= '0;
      rx_sr_q    <= '0;
      tx_cnt_q   <= '0;
      clk_o_q    <= 1'b1;
      dat_o_q    <= 1'b1;
      rx_err_q   <= 1'b0;
      rx_ovf_q   <= 1'b0;
      tx_err_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else if (clk7_en) begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
      clk_prev_q <= clk_s;
      state_q    <= state_d;
      timer_q    <= timer_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_sr_q    <= rx_sr_d;
      tx_cnt_q   <= tx_cnt_d;
      clk_o_q    <= clk_o_d;
      dat_o_q    <= dat_o_d;
      rx_err_q   <= rx_err_d;
      rx_ovf_q   <= rx_ovf_d;
      tx_err_q   <= tx_err_d;
      busy_q     <= busy_d;
    end
  end

endmodule
